// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - state encoding, response status codes and counter width helper for the job sequencer
package fsm_seq_pkg;

    // Sequencer states; one job in flight at a time.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        RUN     = 3'd2,
        BACKOFF = 3'd3,
        RESPOND = 3'd4
    } seq_state_t;

    // Response status codes; 2'b11 is reserved and never produced.
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FAULT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Bits needed to hold 0..max_value, never less than one bit so that
    // MAX_RETRY=0 or BACKOFF_CYC=1 still yields a legal vector.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/fsm_job_sequencer_if.sv
// rtl/fsm_job_sequencer_if.sv - request, controller and response handshake bundle of the job sequencer
interface fsm_job_sequencer_if
    import fsm_seq_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int MAX_RETRY = 2
);

    localparam int RW = cnt_width(MAX_RETRY);

    // job request
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;

    // controller side
    logic            ctrl_start;
    logic            ctrl_busy;
    logic            ctrl_valid;
    logic            ctrl_fault;

    // job response
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [1:0]      rsp_status;
    logic [RW-1:0]   rsp_retries;

    // sequencer view
    modport master (
        input  req_valid, req_id,
        output req_ready,
        output ctrl_start,
        input  ctrl_busy, ctrl_valid, ctrl_fault,
        output rsp_valid, rsp_id, rsp_status, rsp_retries,
        input  rsp_ready
    );

    // issuer, controller and response consumer view
    modport slave (
        output req_valid, req_id,
        input  req_ready,
        input  ctrl_start,
        output ctrl_busy, ctrl_valid, ctrl_fault,
        input  rsp_valid, rsp_id, rsp_status, rsp_retries,
        output rsp_ready
    );

endinterface

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - clearable saturating cycle counter that flags when it reaches its limit
module seq_watchdog
    import fsm_seq_pkg::*;
#(
    parameter int LIMIT = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    // Clear has priority; otherwise count up while enabled and stick at LIMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIM)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LIM);

endmodule

// File: rtl/fsm_job_sequencer.sv
// rtl/fsm_job_sequencer.sv - job issuer with retry, backoff and watchdog for fsm_controller; SEQ_STATS_EN adds event counters
module fsm_job_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int ID_W        = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int BACKOFF_CYC = 4
) (
    input  logic                clk,
    input  logic                reset,
    fsm_job_sequencer_if.master bus
`ifdef SEQ_STATS_EN
    ,
    output logic [15:0]         stat_jobs,
    output logic [15:0]         stat_faults,
    output logic [15:0]         stat_timeouts
`endif
);

    localparam int RW = cnt_width(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    seq_state_t      state;
    logic [ID_W-1:0] job_id;
    logic [RW-1:0]   retry_cnt;

    logic       accept;
    logic       can_retry;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;
    logic       bo_clear;
    logic       bo_enable;
    logic       bo_expired;
    logic       done_now;
    logic [1:0] done_status;

    assign accept    = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign can_retry = (retry_cnt < RETRY_LIM);

    // The watchdog spans a whole attempt: restarted on every entry to LAUNCH,
    // it keeps running across LAUNCH->RUN so the limit covers start + execution.
    assign wd_clear  = accept || ((state == BACKOFF) && bo_expired);
    assign wd_enable = (state == LAUNCH) || (state == RUN);

    // Backoff counter restarts on each retried fault and runs only in BACKOFF.
    assign bo_clear  = (state == RUN) && bus.ctrl_fault && can_retry;
    assign bo_enable = (state == BACKOFF);

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYC - 1)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    seq_watchdog #(
        .LIMIT (BACKOFF_CYC - 1)
    ) u_backoff (
        .clk     (clk),
        .reset   (reset),
        .clear   (bo_clear),
        .enable  (bo_enable),
        .expired (bo_expired)
    );

    // Decide whether the current attempt ends the job this cycle and with what status;
    // fault outranks valid, and either outranks the watchdog.
    always_comb begin
        done_now    = 1'b0;
        done_status = ST_OK;
        case (state)
            LAUNCH: begin
                if (bus.ctrl_busy && wd_expired) begin
                    done_now    = 1'b1;
                    done_status = ST_TIMEOUT;
                end
            end
            RUN: begin
                if (bus.ctrl_fault) begin
                    if (!can_retry) begin
                        done_now    = 1'b1;
                        done_status = ST_FAULT;
                    end
                end else if (bus.ctrl_valid) begin
                    done_now    = 1'b1;
                    done_status = ST_OK;
                end else if (wd_expired) begin
                    done_now    = 1'b1;
                    done_status = ST_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    // Main sequencer FSM with all handshake outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            job_id          <= '0;
            retry_cnt       <= '0;
            bus.req_ready   <= 1'b1;
            bus.ctrl_start  <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_status  <= ST_OK;
            bus.rsp_retries <= '0;
        end else begin
            bus.ctrl_start <= 1'b0;
            if (done_now) begin
                state           <= RESPOND;
                bus.rsp_valid   <= 1'b1;
                bus.rsp_id      <= job_id;
                bus.rsp_status  <= done_status;
                bus.rsp_retries <= retry_cnt;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            job_id        <= bus.req_id;
                            retry_cnt     <= '0;
                            bus.req_ready <= 1'b0;
                            state         <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        if (!bus.ctrl_busy) begin
                            bus.ctrl_start <= 1'b1;
                            state          <= RUN;
                        end
                    end
                    RUN: begin
                        // only a retryable fault reaches here; terminal outcomes go through done_now
                        if (bus.ctrl_fault) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= BACKOFF;
                        end
                    end
                    BACKOFF: begin
                        if (bo_expired) begin
                            state <= LAUNCH;
                        end
                    end
                    RESPOND: begin
                        if (bus.rsp_ready) begin
                            bus.rsp_valid <= 1'b0;
                            bus.req_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_STATS_EN
    // Saturating event counters: completed handshakes, every fault seen in RUN, timeout responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_jobs     <= '0;
            stat_faults   <= '0;
            stat_timeouts <= '0;
        end else begin
            if ((state == RESPOND) && bus.rsp_ready && (stat_jobs != 16'hFFFF)) begin
                stat_jobs <= stat_jobs + 16'd1;
            end
            if ((state == RUN) && bus.ctrl_fault && (stat_faults != 16'hFFFF)) begin
                stat_faults <= stat_faults + 16'd1;
            end
            if (done_now && (done_status == ST_TIMEOUT) && (stat_timeouts != 16'hFFFF)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fsm_job_sequencer.sv
// tb/tb_fsm_job_sequencer.sv - directed and randomized self-checking bench for fsm_job_sequencer
module tb_fsm_job_sequencer;

    localparam int ID_W        = 4;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int BACKOFF_CYC = 4;

    localparam int K_OK     = 0;
    localparam int K_FAULT  = 1;
    localparam int K_SILENT = 2;
    localparam int K_BOTH   = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   att_kind [4];
    int   att_dly  [4];

    fsm_job_sequencer_if #(.ID_W(ID_W), .MAX_RETRY(MAX_RETRY)) bus ();

`ifdef SEQ_STATS_EN
    logic [15:0] stat_jobs;
    logic [15:0] stat_faults;
    logic [15:0] stat_timeouts;
`endif

    fsm_job_sequencer #(
        .ID_W        (ID_W),
        .MAX_RETRY   (MAX_RETRY),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .BACKOFF_CYC (BACKOFF_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SEQ_STATS_EN
        ,
        .stat_jobs     (stat_jobs),
        .stat_faults   (stat_faults),
        .stat_timeouts (stat_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_guard simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_att(input int k0, input int k1, input int k2, input int k3);
        att_kind[0] = k0;
        att_kind[1] = k1;
        att_kind[2] = k2;
        att_kind[3] = k3;
        for (int i = 0; i < 4; i++) att_dly[i] = int'($urandom_range(1, 8));
    endtask

    // Reference outcome of a job from its per-attempt controller behaviour:
    // each fault burns a retry until the budget is gone, then the job reports FAULT.
    function automatic void model_job(input int bh, output logic [1:0] st, output int rt, output int ns);
        rt = 0;
        ns = 0;
        st = 2'b10;
        if (bh >= TIMEOUT_CYC) return;
        for (int a = 0; a < 4; a++) begin
            ns++;
            if (att_kind[a] == K_OK) begin
                st = 2'b00;
                return;
            end
            if (att_kind[a] == K_SILENT) begin
                st = 2'b10;
                return;
            end
            if (rt < MAX_RETRY) rt++;
            else begin
                st = 2'b01;
                return;
            end
        end
    endfunction

    // Issue one job, act as the controller per att_kind/att_dly, hold busy for bh
    // cycles after accept, then stall the response for hold cycles.
    task automatic run_job(input logic [ID_W-1:0] id, input int bh, input int hold);
        logic [1:0] exp_st;
        int exp_rt, exp_ns;
        int acc, starts, att, due, fault_edge, act_edge, g;
        bit done;
        model_job(bh, exp_st, exp_rt, exp_ns);
        starts = 0; att = 0; due = -1; fault_edge = -1000; act_edge = -1; done = 0;
        bus.req_valid = 1'b1;
        bus.req_id    = id;
        g = 0;
        while (bus.req_ready !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        acc = cyc + 1;
        step();
        bus.req_valid = 1'b0;
        bus.req_id    = ID_W'($urandom);
        while (!done && cyc < acc + 1000) begin
            if (bus.ctrl_start === 1'b1) begin
                starts++;
                check("start_after_busy", 32'(cyc >= acc + bh + 1), 32'd1);
                if (starts > 1) check("start_backoff_gap", 32'(cyc - fault_edge >= BACKOFF_CYC), 32'd1);
                if (att < 4) due = cyc + att_dly[att];
            end
            if (bus.rsp_valid === 1'b1) begin
                done = 1;
                bus.ctrl_busy  = 1'b0;
                bus.ctrl_valid = 1'b0;
                bus.ctrl_fault = 1'b0;
                check("rsp_id", 32'(bus.rsp_id), 32'(id));
                check("rsp_status", 32'(bus.rsp_status), 32'(exp_st));
                check("rsp_retries", 32'(bus.rsp_retries), 32'(exp_rt));
                if (exp_st == 2'b10 && exp_rt == 0) check("timeout_latency", 32'(cyc - acc), 32'(TIMEOUT_CYC));
                else if (exp_st != 2'b10) check("rsp_latency", 32'(cyc), 32'(act_edge));
                for (int h = 0; h < hold; h++) begin
                    step();
                    check("hold_valid", 32'(bus.rsp_valid), 32'd1);
                    check("hold_id", 32'(bus.rsp_id), 32'(id));
                    check("hold_status", 32'(bus.rsp_status), 32'(exp_st));
                    check("hold_retries", 32'(bus.rsp_retries), 32'(exp_rt));
                    check("hold_req_ready", 32'(bus.req_ready), 32'd0);
                end
                bus.rsp_ready = 1'b1;
                step();
                bus.rsp_ready = 1'b0;
                check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
                check("req_ready_back", 32'(bus.req_ready), 32'd1);
            end else begin
                check("req_ready_busy", 32'(bus.req_ready), 32'd0);
                bus.ctrl_busy  = (cyc < acc + bh);
                bus.ctrl_valid = 1'b0;
                bus.ctrl_fault = 1'b0;
                if (cyc == due && att < 4) begin
                    if (att_kind[att] == K_OK || att_kind[att] == K_BOTH) bus.ctrl_valid = 1'b1;
                    if (att_kind[att] == K_FAULT || att_kind[att] == K_BOTH) begin
                        bus.ctrl_fault = 1'b1;
                        fault_edge = cyc + 1;
                    end
                    act_edge = cyc + 1;
                    due = -1;
                    att++;
                end
                step();
            end
        end
        if (!done) check("rsp_never_seen", 32'd0, 32'd1);
        check("start_count", 32'(starts), 32'(exp_ns));
    endtask

    initial begin
        int g;
        int r;
        int bh;
        int k [4];
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.ctrl_busy  = 1'b0;
        bus.ctrl_valid = 1'b0;
        bus.ctrl_fault = 1'b0;
        bus.rsp_ready  = 1'b0;
        step();
        step();
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_ctrl_start", 32'(bus.ctrl_start), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_rsp_status", 32'(bus.rsp_status), 32'd0);
        check("reset_rsp_retries", 32'(bus.rsp_retries), 32'd0);
        reset = 1'b1;
        step();

        // nominal: valid 5 cycles after start
        set_att(K_OK, K_OK, K_OK, K_OK);
        att_dly[0] = 5;
        run_job(4'd3, 0, 0);
        // two faults then success
        set_att(K_FAULT, K_FAULT, K_OK, K_OK);
        run_job(4'd5, 0, 1);
        // every attempt faults
        set_att(K_FAULT, K_FAULT, K_FAULT, K_FAULT);
        run_job(4'd6, 0, 0);
        // controller silent after start
        set_att(K_SILENT, K_SILENT, K_SILENT, K_SILENT);
        run_job(4'd7, 0, 0);
        // controller busy for the whole attempt: no start at all
        set_att(K_OK, K_OK, K_OK, K_OK);
        run_job(4'd8, 70, 0);
        // busy stall then release, response backpressured for 10 cycles
        set_att(K_OK, K_OK, K_OK, K_OK);
        run_job(4'd10, 3, 10);
        // valid together with fault counts as fault
        set_att(K_BOTH, K_OK, K_OK, K_OK);
        run_job(4'd11, 0, 0);
        set_att(K_FAULT, K_FAULT, K_BOTH, K_OK);
        run_job(4'd12, 0, 2);
        // silent after a retry
        set_att(K_FAULT, K_SILENT, K_OK, K_OK);
        run_job(4'd13, 0, 0);

        // randomized jobs
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 19));
                k[i] = (r < 9) ? K_OK : (r < 17) ? K_FAULT : (r < 19) ? K_BOTH : K_SILENT;
            end
            set_att(k[0], k[1], k[2], k[3]);
            bh = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 3));
            run_job(ID_W'($urandom), bh, int'($urandom_range(0, 3)));
        end

        // reset while the start pulse is high abandons the job
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd9;
        g = 0;
        while (bus.req_ready !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        step();
        bus.req_valid = 1'b0;
        g = 0;
        while (bus.ctrl_start !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        check("mid_start_seen", 32'(bus.ctrl_start), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_ctrl_start", 32'(bus.ctrl_start), 32'd0);
        check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        reset = 1'b1;
        bus.ctrl_valid = 1'b1;
        step();
        bus.ctrl_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
            check("no_stale_start", 32'(bus.ctrl_start), 32'd0);
            check("idle_req_ready", 32'(bus.req_ready), 32'd1);
            step();
        end
        set_att(K_OK, K_OK, K_OK, K_OK);
        run_job(4'd2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
